// File: rtl/peak_interval_meter.sv
// rtl/peak_interval_meter.sv - beat-to-beat interval meter with refractory window, threshold and running average
//
// Purpose:
//   Measures the number of sample strobes between successive accepted peaks
//   from the upstream peak-detection stage. It ignores peaks inside a
//   refractory window and peaks below an amplitude threshold. It also keeps
//   a running mean over the last 2^AVG_LOG2 intervals.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   sample_en      in   one-cycle strobe, peak_data carries a new sample
//   peak_data      in   [DATA_IN_BITS] peak word, 0 = no peak
//   threshold      in   [DATA_IN_BITS] minimum accepted amplitude (unsigned)
//   interval       out  [CNT_BITS] last measured interval in samples
//   interval_valid out  one-cycle pulse when interval updates
//   avg_interval   out  [CNT_BITS] mean of the last 2^AVG_LOG2 intervals
//   avg_valid      out  level, averaging history is full
//   timeout        out  one-cycle pulse on interval counter saturation
//
// Optional feature macro: PEAK_AMP_TRACK_EN
//   When defined, the amplitude of every accepted peak is remembered. The
//   effective threshold becomes max(threshold, last_amp >> 1).

module peak_interval_meter #(
    parameter int DATA_IN_BITS = 16,
    parameter int CNT_BITS     = 16,
    parameter int REFRACTORY   = 50,
    parameter int AVG_LOG2     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_en,
    input  logic [DATA_IN_BITS-1:0] peak_data,
    input  logic [DATA_IN_BITS-1:0] threshold,
    output logic [CNT_BITS-1:0]     interval,
    output logic                    interval_valid,
    output logic [CNT_BITS-1:0]     avg_interval,
    output logic                    avg_valid,
    output logic                    timeout
);

    localparam int N        = 1 << AVG_LOG2;
    localparam int SUM_BITS = CNT_BITS + AVG_LOG2;
    localparam int FW       = AVG_LOG2 + 1;
    localparam logic [CNT_BITS-1:0] CNT_SAT = {{(CNT_BITS-1){1'b1}}, 1'b0};
    localparam logic [CNT_BITS-1:0] REFR    = CNT_BITS'(REFRACTORY);
    localparam logic [FW-1:0]       FILL_N  = FW'(N);

    typedef enum logic [1:0] {IDLE, REFRACT, ARMED} state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   counter_q, counter_d;
    logic [CNT_BITS-1:0]   counter_inc;
    logic [CNT_BITS-1:0]   interval_q, interval_d;
    logic                  interval_valid_q, interval_valid_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_BITS-1:0]   hist_q [N];
    logic [CNT_BITS-1:0]   hist_d [N];
    logic [SUM_BITS-1:0]   sum_q, sum_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [CNT_BITS-1:0]   avg_interval_q, avg_interval_d;
    logic                  avg_valid_q, avg_valid_d;

    logic [DATA_IN_BITS-1:0] eff_thr;
    logic                    candidate;
    logic                    first_peak;
    logic                    accept;
    logic                    sat;

`ifdef PEAK_AMP_TRACK_EN
    logic [DATA_IN_BITS-1:0] last_amp_q, last_amp_d;

    always_comb begin
        eff_thr = ((last_amp_q >> 1) > threshold) ? (last_amp_q >> 1) : threshold;
    end

    always_comb begin
        last_amp_d = last_amp_q;
        if (sat) begin
            last_amp_d = '0;
        end else if (first_peak || accept) begin
            last_amp_d = peak_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_amp_q <= '0;
        end else begin
            last_amp_q <= last_amp_d;
        end
    end
`else
    always_comb begin
        eff_thr = threshold;
    end
`endif

    assign candidate   = sample_en && (peak_data != '0) && (peak_data >= eff_thr);
    assign counter_inc = counter_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Next-state logic. Saturation takes priority over a coincident peak,
    // so that peak is dropped and the next one is a fresh first peak.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        first_peak = 1'b0;
        accept     = 1'b0;
        sat        = 1'b0;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                if (candidate) begin
                    first_peak = 1'b1;
                    state_d    = REFRACT;
                end
            end
            REFRACT: begin
                if (sample_en) begin
                    if (counter_q == CNT_SAT) begin
                        sat       = 1'b1;
                        counter_d = '0;
                        state_d   = IDLE;
                    end else begin
                        counter_d = counter_inc;
                        if (counter_inc == REFR) begin
                            state_d = ARMED;
                        end
                    end
                end
            end
            ARMED: begin
                if (sample_en) begin
                    if (counter_q == CNT_SAT) begin
                        sat       = 1'b1;
                        counter_d = '0;
                        state_d   = IDLE;
                    end else if (candidate) begin
                        accept    = 1'b1;
                        counter_d = '0;
                        state_d   = REFRACT;
                    end else begin
                        counter_d = counter_inc;
                    end
                end
            end
            default: begin
                counter_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // Output logic. The interval counts the current strobe, hence counter+1.
    always_comb begin
        interval_d       = interval_q;
        interval_valid_d = accept;
        timeout_d        = sat;
        if (accept) begin
            interval_d = counter_inc;
        end
    end

    // Averager: consumes the registered interval one cycle after it is
    // published. A saturation clears history but leaves avg_interval as is.
    always_comb begin
        hist_d         = hist_q;
        sum_d          = sum_q;
        fill_d         = fill_q;
        avg_interval_d = avg_interval_q;
        avg_valid_d    = avg_valid_q;
        if (sat) begin
            for (int i = 0; i < N; i++) begin
                hist_d[i] = '0;
            end
            sum_d       = '0;
            fill_d      = '0;
            avg_valid_d = 1'b0;
        end else if (interval_valid_q) begin
            hist_d[0] = interval_q;
            for (int i = 1; i < N; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            sum_d          = sum_q + SUM_BITS'(interval_q) - SUM_BITS'(hist_q[N-1]);
            avg_interval_d = CNT_BITS'(sum_d >> AVG_LOG2);
            fill_d         = (fill_q == FILL_N) ? fill_q : fill_q + 1'b1;
            avg_valid_d    = (fill_d == FILL_N);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            interval_q       <= '0;
            interval_valid_q <= 1'b0;
            timeout_q        <= 1'b0;
            hist_q           <= '{default: '0};
            sum_q            <= '0;
            fill_q           <= '0;
            avg_interval_q   <= '0;
            avg_valid_q      <= 1'b0;
        end else begin
            interval_q       <= interval_d;
            interval_valid_q <= interval_valid_d;
            timeout_q        <= timeout_d;
            hist_q           <= hist_d;
            sum_q            <= sum_d;
            fill_q           <= fill_d;
            avg_interval_q   <= avg_interval_d;
            avg_valid_q      <= avg_valid_d;
        end
    end

    assign interval       = interval_q;
    assign interval_valid = interval_valid_q;
    assign avg_interval   = avg_interval_q;
    assign avg_valid      = avg_valid_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_peak_interval_meter.sv
// tb/tb_peak_interval_meter.sv - scoreboard bench for peak_interval_meter

module tb_peak_interval_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [15:0] peak_data;
    logic [15:0] threshold;
    logic [7:0]  interval;
    logic        interval_valid;
    logic [7:0]  avg_interval;
    logic        avg_valid;
    logic        timeout;

    always #5 clk = ~clk;

    peak_interval_meter #(
        .DATA_IN_BITS(16),
        .CNT_BITS    (8),
        .REFRACTORY  (50),
        .AVG_LOG2    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .peak_data     (peak_data),
        .threshold     (threshold),
        .interval      (interval),
        .interval_valid(interval_valid),
        .avg_interval  (avg_interval),
        .avg_valid     (avg_valid),
        .timeout       (timeout)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int ivl;
        int avg;
        int avgv;
    } exp_t;

    exp_t exp_q[$];
    int   iv_expected = 0;
    int   iv_seen     = 0;

    task automatic expect_iv(input int ivl, input int avg, input int avgv);
        exp_t e;
        e.ivl  = ivl;
        e.avg  = avg;
        e.avgv = avgv;
        exp_q.push_back(e);
        iv_expected++;
    endtask

    // Monitor: interval on the pulse, averager one cycle later
    exp_t cur;
    logic avg_pending = 1'b0;

    always @(negedge clk) begin
        if (avg_pending) begin
            check("avg_interval", avg_interval, cur.avg);
            check("avg_valid", avg_valid, cur.avgv);
            avg_pending = 1'b0;
        end
        if (interval_valid) begin
            iv_seen++;
            check("iv_timeout_excl", timeout, 0);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("interval", interval, cur.ivl);
                avg_pending = 1'b1;
            end
        end
    end

    int pk_pos[$];
    int pk_amp[$];

    task automatic strobe(input logic [15:0] amp);
        sample_en = 1'b1;
        peak_data = amp;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        peak_data = 16'd0;
    endtask

    // n strobes, gap cycles apart; non-peak data is held at 500 between strobes
    task automatic play(input int n, input int gap);
        int idx = 0;
        for (int s = 0; s < n; s++) begin
            if (idx < pk_pos.size() && pk_pos[idx] == s) begin
                strobe(16'(pk_amp[idx]));
                idx++;
            end else begin
                strobe(16'd0);
            end
            if (gap > 1) begin
                peak_data = 16'd500;
                repeat (gap - 1) begin
                    @(posedge clk);
                    #1;
                end
                peak_data = 16'd0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_interval"}, interval, 0);
        check({tag, "_iv"}, interval_valid, 0);
        check({tag, "_avg"}, avg_interval, 0);
        check({tag, "_avgv"}, avg_valid, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        peak_data = 16'd0;
        threshold = 16'd100;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic interval, then leave the meter ARMED with counter 60
        pk_pos = '{0, 80, 160};
        pk_amp = '{500, 500, 500};
        expect_iv(80, 20, 0);
        expect_iv(80, 40, 0);
        play(221, 1);
        repeat (2) @(posedge clk);
        #1;
        check("held_interval", interval, 80);

        // Mid-operation reset
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pk_pos = '{10};
        pk_amp = '{500};
        play(30, 1);
        check("post_reset_iv_count", iv_seen, iv_expected);

        // Refractory window and threshold
        do_reset();
        pk_pos = '{0, 30, 90, 150};
        pk_amp = '{500, 500, 500, 99};
        expect_iv(90, 22, 0);
        play(200, 1);

        // Averaging
        do_reset();
        pk_pos = '{0, 80, 160, 260, 360, 480};
        pk_amp = '{500, 500, 500, 500, 500, 500};
        expect_iv(80, 20, 0);
        expect_iv(80, 40, 0);
        expect_iv(100, 65, 0);
        expect_iv(100, 90, 1);
        expect_iv(120, 100, 1);
        play(481, 1);

        // Saturation: counter reaches 254 after 254 strobes; the 255th times out
        repeat (254) strobe(16'd0);
        check("pre_sat_timeout", timeout, 0);
        check("pre_sat_avgv", avg_valid, 1);
        strobe(16'd500);
        check("sat_timeout", timeout, 1);
        check("sat_avgv", avg_valid, 0);
        check("sat_interval_hold", interval, 120);
        check("sat_iv", interval_valid, 0);
        strobe(16'd0);
        check("sat_pulse_end", timeout, 0);
        pk_pos = '{0, 60};
        pk_amp = '{500, 500};
        expect_iv(60, 15, 0);
        play(70, 1);

        // Gated strobes, one every 4th cycle
        do_reset();
        pk_pos = '{0, 70};
        pk_amp = '{500, 500};
        expect_iv(70, 17, 0);
        play(71, 4);
        repeat (4) @(posedge clk);
        #1;

        check("iv_count", iv_seen, iv_expected);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
